bus_cdc_tx: RTL and testbench

Source-side half of the team's toggle-handshake bus clock-domain crossing. Accepts a BUS_WIDTH word on a valid/ready interface in the sending clock domain. It then does three things:
- Holds the word stable on TX_DATA.
- Toggles TX_REQ.
- Waits for the destination's toggled RX_ACK, re-synchronized locally, before accepting the next word.

The destination-domain multi-bit synchronizer samples TX_DATA and TX_REQ and returns RX_ACK.

---
 rtl/bus_cdc_pkg.sv | 19 +
 rtl/bus_cdc_tx_ack_sync.sv | 24 ++
 rtl/bus_cdc_tx.sv | 136 +++++++++++++
 tb/tb_bus_cdc_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_cdc_pkg.sv
// Shared types and defaults for the toggle-handshake bus CDC.
// Holds the source FSM state enum and counter-width helper.
package bus_cdc_pkg;

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_WAIT_ACK
   } state_e;

   localparam int unsigned BUS_WIDTH_DEF  = 8;
   localparam int unsigned NUM_STAGES_DEF = 2;
   localparam int unsigned TIMEOUT_DEF    = 255;

   function automatic int unsigned cnt_width(input int unsigned limit);
      return $clog2(limit + 1);
   endfunction

endpackage

// File: rtl/bus_cdc_tx_ack_sync.sv
// Flop-chain synchronizer bringing RX_ACK into the source clock.
// Depth is NUM_STAGES; all stages reset to 0.
module ack_sync #(
   parameter int unsigned NUM_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic ack_s_o
);

   logic [NUM_STAGES-1:0] sync_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[NUM_STAGES-2:0], async_i};
      end
   end

   assign ack_s_o = sync_q[NUM_STAGES-1];

endmodule

// File: rtl/bus_cdc_tx.sv
// Source half of the toggle-handshake bus CDC (valid/ready in, req/ack out).
// Optional sticky ack-timeout flag enabled by BUS_CDC_TX_TIMEOUT_EN.
module bus_cdc_tx
   import bus_cdc_pkg::*;
#(
   parameter int unsigned BUS_WIDTH  = BUS_WIDTH_DEF,
   parameter int unsigned NUM_STAGES = NUM_STAGES_DEF,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [BUS_WIDTH-1:0] in_data_i,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   output logic [BUS_WIDTH-1:0] tx_data_o,
   output logic                 tx_req_o,
   input  logic                 rx_ack_i,
   output logic                 busy_o,
   output logic                 err_o
);

   state_e               state_q, state_d;
   logic [BUS_WIDTH-1:0] data_q, data_d;
   logic                 req_q, req_d;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 ack_s;
   logic                 accept;

   // Illegal parameter sets elaborate this empty marker block
   if (NUM_STAGES < 2 || TIMEOUT < 1) begin : g_illegal_params
   end

   ack_sync #(
      .NUM_STAGES (NUM_STAGES)
   ) u_ack_sync (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .async_i (rx_ack_i),
      .ack_s_o (ack_s)
   );

   assign accept = (state_q == ST_IDLE) && in_valid_i && ready_q;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      req_d   = req_q;
      ready_d = ready_q;
      busy_d  = busy_q;
      unique case (state_q)
         ST_INIT: begin
            state_d = ST_IDLE;
            ready_d = 1'b1;
         end
         ST_IDLE: begin
            if (accept) begin
               state_d = ST_WAIT_ACK;
               data_d  = in_data_i;
               req_d   = ~req_q;
               ready_d = 1'b0;
               busy_d  = 1'b1;
            end
         end
         ST_WAIT_ACK: begin
            if (ack_s == req_q) begin
               state_d = ST_IDLE;
               ready_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_INIT;
            ready_d = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_INIT;
         data_q  <= '0;
         req_q   <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         req_q   <= req_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign in_ready_o = ready_q;
   assign tx_data_o  = data_q;
   assign tx_req_o   = req_q;
   assign busy_o     = busy_q;

`ifdef BUS_CDC_TX_TIMEOUT_EN
   localparam int unsigned CW = cnt_width(TIMEOUT);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;

   // Saturating wait counter; the handshake itself is never aborted
   always_comb begin
      cnt_d = cnt_q;
      err_d = err_q;
      if (accept) begin
         cnt_d = '0;
      end else if (state_q == ST_WAIT_ACK && cnt_q != CW'(TIMEOUT)) begin
         cnt_d = cnt_q + CW'(1);
      end
      if (cnt_d == CW'(TIMEOUT)) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign err_o = err_q;
`else
   assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cdc_tx.sv
// Self-checking bench for bus_cdc_tx: vector table, directed corners,
// randomized traffic against a transfer-level timing model.
module tb_bus_cdc_tx;

   localparam int BW = 8;
   localparam int NS = 2;
   localparam int TO = 10;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [BW-1:0] in_data = '0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [BW-1:0] tx_data;
   logic          tx_req;
   logic          rx_ack = 1'b0;
   logic          busy;
   logic          err;

   int total = 0;
   int bad = 0;

`ifdef BUS_CDC_TX_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   bus_cdc_tx #(
      .BUS_WIDTH  (BW),
      .NUM_STAGES (NS),
      .TIMEOUT    (TO)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .in_data_i  (in_data),
      .in_valid_i (in_valid),
      .in_ready_o (in_ready),
      .tx_data_o  (tx_data),
      .tx_req_o   (tx_req),
      .rx_ack_i   (rx_ack),
      .busy_o     (busy),
      .err_o      (err)
   );

   typedef struct {
      logic          v;
      logic [BW-1:0] d;
      logic          a;
      logic          r;
      logic          q;
      logic [BW-1:0] x;
      logic          b;
   } vec_t;

   vec_t tbl[18];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [BW-1:0] d,
                               input logic a, input logic r,
                               input logic q, input logic [BW-1:0] x,
                               input logic b);
      vec_t t;
      t.v = v; t.d = d; t.a = a;
      t.r = r; t.q = q; t.x = x; t.b = b;
      return t;
   endfunction

   task automatic xfer(input logic [BW-1:0] w, input logic exp_req);
      int n;
      in_valid = 1'b1;
      in_data  = w;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      if (n >= 50) chk("b2b_ready_to", 0, 1);
      tick();
      in_valid = 1'b0;
      chk("b2b_req", tx_req, exp_req);
      chk("b2b_data", tx_data, w);
      chk("b2b_busy", busy, 1);
      rx_ack = exp_req;
      n = 0;
      while (busy && n < 20) begin
         tick();
         chk("b2b_stable", tx_data, w);
         n++;
      end
      if (n >= 20) chk("b2b_ack_to", 0, 1);
   endtask

   initial begin
      logic          m_ready;
      logic          m_busy;
      logic          m_req;
      logic [BW-1:0] m_data;
      int            e;
      int            ack_edge;
      int            ready_edge;
      int            n;
      logic          v;
      logic [BW-1:0] d;

      tbl[0]  = mk(1, 8'hA5, 0, 0, 1, 8'hA5, 1);
      tbl[1]  = mk(1, 8'h3C, 0, 0, 1, 8'hA5, 1);
      tbl[2]  = mk(1, 8'h3C, 0, 0, 1, 8'hA5, 1);
      tbl[3]  = mk(1, 8'h3C, 0, 0, 1, 8'hA5, 1);
      tbl[4]  = mk(1, 8'h3C, 0, 0, 1, 8'hA5, 1);
      tbl[5]  = mk(1, 8'h3C, 1, 0, 1, 8'hA5, 1);
      tbl[6]  = mk(1, 8'h3C, 1, 0, 1, 8'hA5, 1);
      tbl[7]  = mk(1, 8'h3C, 1, 1, 1, 8'hA5, 0);
      tbl[8]  = mk(1, 8'h3C, 1, 0, 0, 8'h3C, 1);
      tbl[9]  = mk(0, 8'h00, 1, 0, 0, 8'h3C, 1);
      tbl[10] = mk(0, 8'h00, 0, 0, 0, 8'h3C, 1);
      tbl[11] = mk(0, 8'h00, 0, 0, 0, 8'h3C, 1);
      tbl[12] = mk(0, 8'h00, 0, 1, 0, 8'h3C, 0);
      tbl[13] = mk(0, 8'h77, 0, 1, 0, 8'h3C, 0);
      tbl[14] = mk(0, 8'h77, 1, 1, 0, 8'h3C, 0);
      tbl[15] = mk(0, 8'h77, 1, 1, 0, 8'h3C, 0);
      tbl[16] = mk(0, 8'h77, 0, 1, 0, 8'h3C, 0);
      tbl[17] = mk(0, 8'h77, 0, 1, 0, 8'h3C, 0);

      // reset state
      #3;
      chk("rst_ready", in_ready, 0);
      chk("rst_req", tx_req, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("rel_ready", in_ready, 1);
      chk("rel_req", tx_req, 0);

      // single transfer, hold while busy, idle ack violation
      for (int i = 0; i < 18; i++) begin
         in_valid = tbl[i].v;
         in_data  = tbl[i].d;
         rx_ack   = tbl[i].a;
         tick();
         chk($sformatf("vec%0d_ready", i), in_ready, tbl[i].r);
         chk($sformatf("vec%0d_req", i), tx_req, tbl[i].q);
         chk($sformatf("vec%0d_data", i), tx_data, tbl[i].x);
         chk($sformatf("vec%0d_busy", i), busy, tbl[i].b);
      end

      // back-to-back words
      xfer(8'h01, 1'b1);
      xfer(8'h02, 1'b0);
      xfer(8'h03, 1'b1);

      // randomized traffic vs. transfer-level timing model
      m_ready = 1'b1;
      m_busy  = 1'b0;
      m_req   = 1'b1;
      m_data  = 8'h03;
      e = 0;
      ack_edge = 0;
      ready_edge = 0;
      for (int s = 0; s < 300; s++) begin
         v = 1'($urandom_range(0, 1));
         d = BW'($urandom);
         in_valid = v;
         in_data  = d;
         if (m_busy && (e + 1) == ack_edge) rx_ack = m_req;
         tick();
         e++;
         if (m_ready && v) begin
            m_req      = ~m_req;
            m_data     = d;
            m_ready    = 1'b0;
            m_busy     = 1'b1;
            ack_edge   = e + 1 + int'($urandom_range(0, 4));
            ready_edge = ack_edge + NS;
         end else if (m_busy && e == ready_edge) begin
            m_ready = 1'b1;
            m_busy  = 1'b0;
         end
         chk("rnd_ready", in_ready, m_ready);
         chk("rnd_req", tx_req, m_req);
         chk("rnd_data", tx_data, m_data);
         chk("rnd_busy", busy, m_busy);
      end

      // mid-transfer reset
      in_valid = 1'b0;
      rx_ack = 1'b0;
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      in_valid = 1'b1;
      in_data  = 8'h99;
      tick();
      in_valid = 1'b0;
      chk("mr_req_pre", tx_req, 1);
      chk("mr_busy_pre", busy, 1);
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("mr_req", tx_req, 0);
      chk("mr_data", tx_data, 0);
      chk("mr_busy", busy, 0);
      chk("mr_ready", in_ready, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("mr_rel_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      tick();
      in_valid = 1'b0;
      chk("mr_next_req", tx_req, 1);
      chk("mr_next_data", tx_data, 8'h5A);

      // ack withheld: timeout flag (or constant 0 when compiled out)
      for (int i = 1; i < TO; i++) tick();
      chk("to_before", err, 0);
      tick();
      chk("to_at", err, TO_EN);
      for (int i = 0; i < 5; i++) tick();
      chk("to_sticky", err, TO_EN);
      chk("to_still_busy", busy, 1);
      rx_ack = 1'b1;
      n = 0;
      while (!in_ready && n < 20) begin
         tick();
         n++;
      end
      if (n >= 20) chk("late_ack_to", 0, 1);
      chk("late_ack_ready", in_ready, 1);
      chk("late_ack_err", err, TO_EN);
      chk("late_ack_req", tx_req, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
